// File: rtl/gate_response_checker_if.sv
// Stimulus/response bundle between gate_response_checker and its 2-input gate under test.
// The master side is the checker; the slave side is the environment (start source and gate).
interface gate_response_checker_if #(
   parameter int ERR_W = 3
);
   logic             start;
   logic             y;
   logic             a;
   logic             b;
   logic             busy;
   logic             done;
   logic             pass;
   logic [ERR_W-1:0] err_count;
   logic [3:0]       fail_vec;

   modport master (
      input  start, y,
      output a, b, busy, done, pass, err_count, fail_vec
   );

   modport slave (
      output start, y,
      input  a, b, busy, done, pass, err_count, fail_vec
   );
endinterface

// File: rtl/gate_response_checker.sv
// Sweeps {a,b} through 00..11 on a 2-input gate, samples y after a settle interval,
// and reports pass/fail, a saturating mismatch count and a per-vector failure map.
module gate_response_checker #(
   parameter logic [3:0] TRUTH_TABLE   = 4'b0001,
   parameter int         SETTLE_CYCLES = 20,
   parameter int         ERR_W         = 3
) (
   input  logic                      clk,
   input  logic                      rst,
   gate_response_checker_if.master   bus
);

   localparam logic [7:0] SETTLE_LAST = 8'(SETTLE_CYCLES - 1);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      SETTLE = 2'd1,
      SAMPLE = 2'd2,
      DONE   = 2'd3
   } state_t;

   state_t           state_q;
   logic [1:0]       idx_q;
   logic [7:0]       cnt_q;
   logic [1:0]       ab_q;
   logic             busy_q;
   logic             done_q;
   logic             pass_q;
   logic [ERR_W-1:0] err_q;
   logic [3:0]       fail_q;

   logic             mismatch_d;
   logic [ERR_W-1:0] err_d;
   logic [3:0]       fail_d;

   // Result of the comparison taking effect on the edge that ends SAMPLE.
   always_comb begin
      mismatch_d = 1'b0;
      err_d      = err_q;
      fail_d     = fail_q;
      mismatch_d = (bus.y != TRUTH_TABLE[idx_q]);
      if (mismatch_d) begin
         fail_d = fail_q | (4'b0001 << idx_q);
         if (err_q != {ERR_W{1'b1}}) begin
            err_d = err_q + 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         idx_q   <= 2'd0;
         cnt_q   <= 8'd0;
         ab_q    <= 2'b00;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         pass_q  <= 1'b0;
         err_q   <= '0;
         fail_q  <= 4'b0000;
      end else begin
         case (state_q)
            IDLE: begin
               done_q <= 1'b0;
               busy_q <= 1'b0;
               if (bus.start) begin
                  err_q   <= '0;
                  fail_q  <= 4'b0000;
                  pass_q  <= 1'b0;
                  idx_q   <= 2'd0;
                  ab_q    <= 2'b00;
                  cnt_q   <= 8'd0;
                  busy_q  <= 1'b1;
                  state_q <= SETTLE;
               end
            end
            SETTLE: begin
               cnt_q <= cnt_q + 8'd1;
               if (cnt_q == SETTLE_LAST) begin
                  state_q <= SAMPLE;
               end
            end
            SAMPLE: begin
               err_q  <= err_d;
               fail_q <= fail_d;
               if (idx_q == 2'd3) begin
                  // Results are already final here, so pass is valid alongside done.
                  done_q  <= 1'b1;
                  pass_q  <= (err_d == '0);
                  state_q <= DONE;
               end else begin
                  idx_q   <= idx_q + 2'd1;
                  ab_q    <= idx_q + 2'd1;
                  cnt_q   <= 8'd0;
                  state_q <= SETTLE;
               end
            end
            DONE: begin
               done_q  <= 1'b0;
               busy_q  <= 1'b0;
               state_q <= IDLE;
            end
            default: begin
               state_q <= IDLE;
            end
         endcase
      end
   end

   assign bus.a         = ab_q[1];
   assign bus.b         = ab_q[0];
   assign bus.busy      = busy_q;
   assign bus.done      = done_q;
   assign bus.pass      = pass_q;
   assign bus.err_count = err_q;
   assign bus.fail_vec  = fail_q;

endmodule
